mem_port_arbiter: RTL

Shares the core's single 32-bit memory port between the instruction-fetch requester and the load/store (data) requester, one transaction outstanding at a time. It arbitrates with fixed data-over-fetch priority and performs byte-lane steering for RV32I loads and stores using the `common::mem_access_type` encoding. It also handles load sign/zero extension, misalignment trapping and a bus timeout. The block sits between the IF/MEM pipeline stages and the external memory/bus interface.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single 32-bit memory port between instruction fetch and load/store,
// with byte-lane steering, load extension, misalignment trapping and a bus timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_type,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] T_LB  = 4'd0;
  localparam logic [3:0] T_LH  = 4'd1;
  localparam logic [3:0] T_LW  = 4'd2;
  localparam logic [3:0] T_LBU = 4'd3;
  localparam logic [3:0] T_LHU = 4'd4;
  localparam logic [3:0] T_SB  = 4'd5;
  localparam logic [3:0] T_SH  = 4'd6;
  localparam logic [3:0] T_SW  = 4'd7;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t      state_r;
  logic [15:0] tmo_cnt_r;
  logic [3:0]  ld_type_r;
  logic [1:0]  ld_off_r;

  // Illegal encodings (MEM_NONE and above) are treated like misalignment.
  function automatic logic d_fault(input logic [3:0] t, input logic [1:0] a);
    logic bad;
    case (t)
      T_LB, T_LBU, T_SB: bad = 1'b0;
      T_LH, T_LHU, T_SH: bad = a[0];
      T_LW, T_SW:        bad = (a != 2'b00);
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(input logic [3:0] t, input logic [1:0] a);
    logic [3:0] s;
    case (t)
      T_SB:    s = 4'b0001 << a;
      T_SH:    s = a[1] ? 4'b1100 : 4'b0011;
      T_SW:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] t, input logic [31:0] wd);
    logic [31:0] r;
    case (t)
      T_SB:    r = {4{wd[7:0]}};
      T_SH:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Store types fall through to zero so d_rdata reads 0 after a store.
  function automatic logic [31:0] load_extend(input logic [3:0] t, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      T_LB:    r = {{24{b[7]}}, b};
      T_LBU:   r = {24'd0, b};
      T_LH:    r = {{16{h[15]}}, h};
      T_LHU:   r = {16'd0, h};
      T_LW:    r = w;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Arbitration FSM with all port outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      tmo_cnt_r <= 16'd0;
      ld_type_r <= 4'd0;
      ld_off_r  <= 2'd0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'd0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'd0;
      mem_wdata <= 32'd0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'd0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (d_req) begin
            if (d_fault(d_type, d_addr[1:0])) begin
              state_r <= RESP;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= 32'd0;
            end else begin
              state_r   <= DATA;
              tmo_cnt_r <= 16'd0;
              ld_type_r <= d_type;
              ld_off_r  <= d_addr[1:0];
              mem_valid <= 1'b1;
              mem_addr  <= {d_addr[31:2], 2'b00};
              mem_wstrb <= store_strb(d_type, d_addr[1:0]);
              mem_we    <= (store_strb(d_type, d_addr[1:0]) != 4'd0);
              mem_wdata <= store_data(d_type, d_wdata);
            end
          end else if (if_req) begin
            if (if_addr[1:0] != 2'b00) begin
              state_r  <= RESP;
              if_ack   <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= 32'd0;
            end else begin
              state_r   <= FETCH;
              tmo_cnt_r <= 16'd0;
              mem_valid <= 1'b1;
              mem_addr  <= {if_addr[31:2], 2'b00};
              mem_we    <= 1'b0;
              mem_wstrb <= 4'd0;
            end
          end
        end
        FETCH: begin
          if (mem_ready || (tmo_cnt_r == TMO_LAST)) begin
            state_r   <= RESP;
            mem_valid <= 1'b0;
            if_ack    <= 1'b1;
            if_err    <= !mem_ready;
            if_rdata  <= mem_ready ? mem_rdata : 32'd0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (mem_ready || (tmo_cnt_r == TMO_LAST)) begin
            state_r   <= RESP;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'd0;
            d_ack     <= 1'b1;
            d_err     <= !mem_ready;
            d_rdata   <= mem_ready ? load_extend(ld_type_r, ld_off_r, mem_rdata) : 32'd0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          if_err  <= 1'b0;
          d_err   <= 1'b0;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
